// File: rtl/scan_test_ctrl_if.sv
// scan_test_ctrl_if: request, result and serial scan signals between a test requester/target chain and scan_test_ctrl
// ports: start/pattern/expected/scan_out towards the controller; scan_en/scan_in/captured/busy/done/pass back
interface scan_test_ctrl_if #(parameter int CHAIN_LEN = 2);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern;
  logic [CHAIN_LEN-1:0] expected;
  logic                 scan_out;
  logic                 scan_en;
  logic                 scan_in;
  logic [CHAIN_LEN-1:0] captured;
  logic                 busy;
  logic                 done;
  logic                 pass;
  modport master (output start, pattern, expected, scan_out,
                  input  scan_en, scan_in, captured, busy, done, pass);
  modport slave  (input  start, pattern, expected, scan_out,
                  output scan_en, scan_in, captured, busy, done, pass);
endinterface

// File: rtl/scan_test_ctrl.sv
// scan_test_ctrl: shifts a pattern into a scan chain, runs capture cycles, unloads and compares the response
// ports: clk, reset (sync, active-low), bus (slave modport: start/pattern/expected/scan_out in, scan_en/scan_in/captured/busy/done/pass out)
module scan_test_ctrl #(
  parameter int CHAIN_LEN      = 2,
  parameter int CAPTURE_CYCLES = 1
) (
  input logic             clk,
  input logic             reset,
  scan_test_ctrl_if.slave bus
);
  localparam int MX = CHAIN_LEN > CAPTURE_CYCLES ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] NL = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] NE = CW'(CHAIN_LEN);
  localparam logic [CW-1:0] CL = CW'(CAPTURE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CHAIN_LEN-1:0] sh_q, exp_q, cap_q, cap_d;
  logic                 en_q, si_q, busy_q, done_q, pass_q;
  always_comb cap_d = (cap_q << 1) | CHAIN_LEN'(bus.scan_out);
  // SHIFT_OUT runs one extra cycle with scan_en low so the compare sees the final captured word
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      en_q    <= 1'b0;
      si_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= SHIFT_IN;
          sh_q    <= bus.pattern << 1;
          exp_q   <= bus.expected;
          cap_q   <= '0;
          pass_q  <= 1'b0;
          en_q    <= 1'b1;
          si_q    <= bus.pattern[CHAIN_LEN-1];
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
        SHIFT_IN: if (cnt_q == NL) begin
          state_q <= CAPTURE;
          en_q    <= 1'b0;
          si_q    <= 1'b0;
          cnt_q   <= '0;
        end else begin
          si_q  <= sh_q[CHAIN_LEN-1];
          sh_q  <= sh_q << 1;
          cnt_q <= cnt_q + 1'b1;
        end
        CAPTURE: if (cnt_q == CL) begin
          state_q <= SHIFT_OUT;
          en_q    <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        SHIFT_OUT: if (cnt_q == NE) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= cap_q == exp_q;
          cnt_q   <= '0;
        end else begin
          cap_q <= cap_d;
          en_q  <= cnt_q != NL;
          cnt_q <= cnt_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  assign bus.scan_en  = en_q;
  assign bus.scan_in  = si_q;
  assign bus.captured = cap_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
endmodule

// File: doc/scan_test_ctrl.md
Name: scan_test_ctrl

Overview:
Scan-chain test initiator that drives the other end of the team's scan-DFF chains, such as the scan FSM state chain. On a start request it shifts a parallel pattern serially into the chain and releases scan_en for functional capture cycles. It then shifts the captured response back out and compares it against an expected word. It sits beside the DUT chain, owns scan_en/scan_in and consumes scan_out.

Parameters:
CHAIN_LEN, 2, number of scan flops in the target chain (>=1)
CAPTURE_CYCLES, 1, functional clock cycles with scan_en low between shift-in and shift-out (>=1)

Ports:
clk  input  1  rising-edge clock, shared with the DUT chain
reset  input  1  synchronous, active-low reset
start  input  1  request one test; sampled only in IDLE
pattern  input  CHAIN_LEN  value to load; bit i lands in chain flop i (flop 0 nearest scan_in)
expected  input  CHAIN_LEN  expected captured chain state, same bit mapping
scan_out  input  1  serial output of the chain's last flop (CHAIN_LEN-1)
scan_en  output  1  chain shift enable, registered
scan_in  output  1  serial data into chain flop 0, registered
captured  output  CHAIN_LEN  response unloaded from the chain, same bit mapping
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse when the result is valid
pass  output  1  captured == expected; valid from done, held until the next start

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0, counters=0. This applies from any state; an in-flight test is abandoned with no done.
- States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.
- IDLE: start=1 at an edge latches pattern and expected into internal registers, clears captured and pass, and moves to SHIFT_IN. start is ignored in every other state.
- SHIFT_IN: CHAIN_LEN cycles; scan_en=1.
  - scan_in presents latched pattern MSB first: cycle k drives pattern[CHAIN_LEN-1-k].
  - After the CHAIN_LEN-th edge, chain flop i holds pattern[i]; move to CAPTURE.
- CAPTURE: CAPTURE_CYCLES cycles; scan_en=0, scan_in=0. The DUT flops load their functional next-state. Then move to SHIFT_OUT.
- SHIFT_OUT: CHAIN_LEN cycles; scan_en=1, scan_in=0.
  - At each edge, captured <= {captured[CHAIN_LEN-2:0], scan_out}; for CHAIN_LEN=1, captured <= scan_out.
  - After CHAIN_LEN edges, captured[i] equals the post-capture value of flop i; move to DONE.
- DONE: exactly one cycle; done=1, busy=0, scan_en=0, pass=(captured==expected). Then return to IDLE. A start asserted during DONE is ignored; it is accepted from the next IDLE cycle.
- Latency: if start is accepted at edge E, scan_en is first high after E, and done is high in the cycle following edge E+2*CHAIN_LEN+CAPTURE_CYCLES+1.
- busy is high in the SHIFT_IN, CAPTURE and SHIFT_OUT states only.
- Counter width: $clog2 of max(CHAIN_LEN, CAPTURE_CYCLES)+1. Each counter resets to 0 on every state entry; no wrap is ever observable.
- pattern and expected may change after acceptance without affecting the running test.
- captured and pass hold their values through IDLE until the next accepted start.

Test Plan:
- Chain = scan_fsm, in=1, pattern=2'b01 (LOAD), expected=2'b10, start pulse -> scan_in sequence 0,1 with scan_en=1 for 2 cycles; scan_en=0 for 1 cycle; done 6 edges after the start edge; captured=2'b10, pass=1.
- scan_fsm, in=0, pattern=2'b10 (DONE), expected=2'b10 -> captured=2'b10, pass=1; repeat with expected=2'b01 -> pass=0, captured=2'b10.
- scan_fsm, in=1, pattern=2'b11 (illegal state), expected=2'b00 -> default branch gives captured=2'b00, pass=1.
- Assert reset=0 during cycle 2 of SHIFT_OUT -> next edge: scan_en=0, busy=0, captured=0, no done pulse; a following start with pattern=2'b00, in=1 yields captured=2'b01.
- Hold start=1 continuously -> tests run back to back with one IDLE cycle between each DONE and the next SHIFT_IN; pulsing start while busy has no effect on cycle counts.
- CHAIN_LEN=4, CAPTURE_CYCLES=3 with a behavioural 4-flop shift model, pattern=4'b1011, capture behaves as identity -> scan_in sequence 1,0,1,1; captured=4'b1011; done 12 edges after the start edge.
